// File: rtl/ternary_pkg.sv
// Shared ternary datapath types: 2-bit trit encoding, writeback entry layout
// and an invalid-trit detector used by the writeback stage.
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t T_ZERO    = 2'b00;
  localparam trit_t T_POS_ONE = 2'b01;
  localparam trit_t T_NEG_ONE = 2'b10;
  localparam trit_t T_INVALID = 2'b11;

  // Datapath geometry shared with the ALU.
  localparam int WB_WIDTH = 8;
  localparam int WB_RD_W  = 3;

  typedef struct packed {
    trit_t [WB_WIDTH-1:0] result;
    trit_t                carry;
    logic                 zero;
    logic                 neg;
    logic [WB_RD_W-1:0]   rd;
    logic                 wen;
    logic                 fupd;
  } wb_entry_t;

  function automatic logic has_invalid(input wb_entry_t e);
    logic bad;
    bad = (e.carry == T_INVALID);
    for (int i = 0; i < WB_WIDTH; i++) begin
      if (e.result[i] == T_INVALID) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/ternary_skid_buf.sv
// Two-entry skid buffer (output register + skid register) with a registered
// in_ready that is high exactly when the skid register is empty.
module ternary_skid_buf #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic          skid_full;
  logic [PW-1:0] skid_q;
  logic [PW-1:0] out_q;
  logic          accept;

  assign accept   = in_valid & in_ready;
  assign out_data = out_q;

  // NOTE: only the occupancy bits are reset; payload registers are always
  // qualified by out_valid/skid_full, so clearing them would add nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      in_ready  <= 1'b1;
    end else if (!out_valid || out_ready) begin
      // Output register is free this edge: refill from skid first to keep order.
      if (skid_full) begin
        out_q     <= skid_q;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
        in_ready  <= 1'b1;
      end else begin
        out_valid <= accept;
        if (accept) out_q <= in_data;
      end
    end else if (accept) begin
      skid_q    <= in_data;
      skid_full <= 1'b1;
      in_ready  <= 1'b0;
    end
  end

endmodule

// File: rtl/ternary_wb_stage.sv
// Ternary ALU writeback stage: skid-buffered handshake, invalid-trit masking,
// architectural flags and an optional bypass enabled by TERNARY_WB_FWD_EN.
module ternary_wb_stage
  import ternary_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH,
  parameter int RD_W  = WB_RD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  trit_t [WIDTH-1:0]    in_result,
  input  trit_t                in_carry,
  input  logic                 in_zero,
  input  logic                 in_neg,
  input  logic [RD_W-1:0]      in_rd,
  input  logic                 in_wen,
  input  logic                 in_fupd,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output trit_t [WIDTH-1:0]    wb_data,
  output logic [RD_W-1:0]      wb_rd,
  output logic                 wb_wen,
  output logic                 flag_zero,
  output logic                 flag_neg,
  output trit_t                flag_carry,
  output logic                 err_invalid,
  output logic                 fwd_valid,
  output logic [RD_W-1:0]      fwd_rd,
  output trit_t [WIDTH-1:0]    fwd_data
);

  wb_entry_t in_entry;
  wb_entry_t out_entry;
  logic      out_valid;
  logic      out_bad;
  logic      wb_fire;

  assign in_entry = '{result: in_result, carry: in_carry, zero: in_zero,
                      neg: in_neg, rd: in_rd, wen: in_wen, fupd: in_fupd};

  ternary_skid_buf #(
    .PW($bits(wb_entry_t))
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (wb_ready),
    .out_data  (out_entry)
  );

  assign out_bad  = has_invalid(out_entry);
  assign wb_fire  = out_valid & wb_ready;

  // Idle outputs read as zero so the register file never sees stale payload.
  assign wb_valid = out_valid;
  assign wb_data  = out_valid ? out_entry.result : '0;
  assign wb_rd    = out_valid ? out_entry.rd : '0;
  assign wb_wen   = out_valid & out_entry.wen & ~out_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_zero   <= 1'b0;
      flag_neg    <= 1'b0;
      flag_carry  <= T_ZERO;
      err_invalid <= 1'b0;
    end else if (wb_fire) begin
      if (out_bad) begin
        err_invalid <= 1'b1;
      end else if (out_entry.fupd) begin
        flag_zero  <= out_entry.zero;
        flag_neg   <= out_entry.neg;
        flag_carry <= out_entry.carry;
      end
    end
  end

`ifdef TERNARY_WB_FWD_EN
  assign fwd_valid = wb_valid & wb_wen;
  assign fwd_rd    = wb_rd;
  assign fwd_data  = wb_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ternary_wb_stage.sv
// Self-checking bench for ternary_wb_stage: directed vector table, hand-built
// stall/reset/bypass sequences, then random traffic against a queue model.
module tb_ternary_wb_stage;
  import ternary_pkg::*;

  localparam int W  = 8;
  localparam int RW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [2*W-1:0]  in_result;
  logic [1:0]      in_carry;
  logic            in_zero, in_neg, in_wen, in_fupd;
  logic [RW-1:0]   in_rd;
  logic            wb_valid, wb_ready, wb_wen;
  logic [2*W-1:0]  wb_data;
  logic [RW-1:0]   wb_rd;
  logic            flag_zero, flag_neg, err_invalid;
  logic [1:0]      flag_carry;
  logic            fwd_valid;
  logic [RW-1:0]   fwd_rd;
  logic [2*W-1:0]  fwd_data;

  always #5 clk = ~clk;

  ternary_wb_stage #(.WIDTH(W), .RD_W(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry),
    .in_zero(in_zero), .in_neg(in_neg), .in_rd(in_rd),
    .in_wen(in_wen), .in_fupd(in_fupd),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .flag_zero(flag_zero), .flag_neg(flag_neg), .flag_carry(flag_carry),
    .err_invalid(err_invalid),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  typedef struct {
    logic [2*W-1:0] result;
    logic [1:0]     carry;
    logic           zero;
    logic           neg;
    logic [RW-1:0]  rd;
    logic           wen;
    logic           fupd;
  } word_t;

  typedef struct {
    word_t      w;
    logic       exp_wen;
    logic       exp_z;
    logic       exp_n;
    logic [1:0] exp_c;
    logic       exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t mk(input logic [2*W-1:0] r, input logic [1:0] c,
                               input logic z, input logic n, input logic [RW-1:0] rd,
                               input logic wen, input logic fupd);
    word_t w;
    w.result = r; w.carry = c; w.zero = z; w.neg = n;
    w.rd = rd; w.wen = wen; w.fupd = fupd;
    return w;
  endfunction

  // Reference rule: a word is poisoned if any of its trits uses the 2'b11 code.
  function automatic bit word_bad(input word_t w);
    bit b;
    b = (w.carry == 2'b11);
    for (int i = 0; i < W; i++) if (w.result[2*i +: 2] == 2'b11) b = 1'b1;
    return b;
  endfunction

  task automatic drive(input word_t w, input logic v);
    in_valid = v; in_result = w.result; in_carry = w.carry;
    in_zero = w.zero; in_neg = w.neg; in_rd = w.rd;
    in_wen = w.wen; in_fupd = w.fupd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(mk('0, 2'b00, 0, 0, 0, 0, 0), 1'b0);
    wb_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  vec_t  vecs [7];
  word_t q [$];
  word_t w, w0;
  logic  mz, mn, merr, v, rdy, r, acc;
  logic [1:0] mc;
  logic  exp_fv;
  logic [RW-1:0]  exp_frd;
  logic [2*W-1:0] exp_fd;

  initial begin
    // trit i occupies bits [2i+1:2i]; 01=+1, 10=-1, 11=invalid
    vecs[0] = '{mk(16'h0001, 2'b00, 0, 0, 3, 1, 1), 1, 0, 0, 2'b00, 0};
    vecs[1] = '{mk(16'h0000, 2'b10, 1, 0, 1, 0, 1), 0, 1, 0, 2'b10, 0};
    vecs[2] = '{mk(16'h0012, 2'b01, 0, 1, 4, 1, 0), 1, 1, 0, 2'b10, 0};
    vecs[3] = '{mk(16'h8000, 2'b01, 0, 1, 7, 1, 1), 1, 0, 1, 2'b01, 0};
    vecs[4] = '{mk(16'h0C00, 2'b10, 1, 0, 5, 1, 1), 0, 0, 1, 2'b01, 1};
    vecs[5] = '{mk(16'h0000, 2'b00, 1, 0, 6, 1, 1), 1, 1, 0, 2'b00, 1};
    vecs[6] = '{mk(16'h0005, 2'b11, 0, 1, 2, 1, 1), 0, 1, 0, 2'b00, 1};

    do_reset();
    check("reset wb_valid", wb_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset wb_data", wb_data, 0);
    check("reset flags", {flag_zero, flag_neg, flag_carry, err_invalid}, 0);
    check("reset fwd_valid", fwd_valid, 0);

    // Directed vectors, one word at a time with the register file always ready.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].w, 1'b1);
      wb_ready = 1'b1;
      tick();
      drive(vecs[i].w, 1'b0);
      check($sformatf("vec%0d wb_valid", i), wb_valid, 1);
      check($sformatf("vec%0d wb_rd", i), wb_rd, vecs[i].w.rd);
      check($sformatf("vec%0d wb_data", i), wb_data, vecs[i].w.result);
      check($sformatf("vec%0d wb_wen", i), wb_wen, vecs[i].exp_wen);
      tick();
      check($sformatf("vec%0d idle data", i), {wb_valid, wb_data, wb_rd, wb_wen}, 0);
      check($sformatf("vec%0d flags", i), {flag_zero, flag_neg, flag_carry},
            {vecs[i].exp_z, vecs[i].exp_n, vecs[i].exp_c});
      check($sformatf("vec%0d err", i), err_invalid, vecs[i].exp_err);
    end
    tick();
    tick();
    check("err sticky", err_invalid, 1);
    do_reset();
    check("err cleared by rst", err_invalid, 0);

    // Three words offered against a stalled register file.
    wb_ready = 1'b0;
    drive(mk(16'h0001, 2'b00, 0, 0, 1, 1, 0), 1'b1);
    tick();
    check("stall w1 in_ready", in_ready, 1);
    check("stall w1 out", {wb_valid, wb_rd}, {1'b1, 3'd1});
    drive(mk(16'h0002, 2'b00, 0, 0, 2, 1, 0), 1'b1);
    tick();
    check("stall w2 in_ready", in_ready, 0);
    check("stall w2 out", wb_rd, 1);
    drive(mk(16'h0004, 2'b00, 0, 0, 3, 1, 0), 1'b1);
    tick();
    check("stall w3 refused", in_ready, 0);
    check("stall hold w1", {wb_rd, wb_data}, {3'd1, 16'h0001});
    wb_ready = 1'b1;
    tick();
    check("release out w2", {wb_rd, wb_data}, {3'd2, 16'h0002});
    check("release in_ready", in_ready, 1);
    tick();
    drive(mk(16'h0004, 2'b00, 0, 0, 3, 1, 0), 1'b0);
    check("release out w3", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd3, 16'h0004});
    tick();
    check("release empty", wb_valid, 0);

    // Reset while both entries hold flag-updating words and wb_ready is high.
    do_reset();
    drive(mk(16'h0001, 2'b01, 1, 1, 4, 1, 1), 1'b1);
    tick();
    drive(mk(16'h0002, 2'b01, 1, 1, 5, 1, 1), 1'b1);
    tick();
    check("full before rst", {wb_valid, in_ready}, 2'b10);
    drive(mk(16'h0002, 2'b01, 1, 1, 5, 1, 1), 1'b0);
    rst = 1'b1;
    wb_ready = 1'b1;
    tick();
    rst = 1'b0;
    check("rst mid-stall", {wb_valid, in_ready, flag_zero, flag_neg, flag_carry},
          {1'b0, 1'b1, 1'b0, 1'b0, 2'b00});

    // Bypass visibility across a stall.
    do_reset();
    w = mk(16'h4321, 2'b00, 0, 0, 2, 1, 0);
    drive(w, 1'b1);
    tick();
    drive(w, 1'b0);
`ifdef TERNARY_WB_FWD_EN
    exp_fv = 1'b1; exp_frd = 3'd2; exp_fd = w.result;
`else
    exp_fv = 1'b0; exp_frd = 3'd0; exp_fd = '0;
`endif
    for (int i = 0; i < 3; i++) begin
      check($sformatf("fwd stall%0d", i), {fwd_valid, fwd_rd, fwd_data}, {exp_fv, exp_frd, exp_fd});
      tick();
    end
    wb_ready = 1'b1;
    tick();
    check("fwd after drain", fwd_valid, 0);

    // Random traffic against a FIFO-of-two reference model.
    do_reset();
    q.delete();
    mz = 0; mn = 0; mc = 2'b00; merr = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      check("rnd in_ready", in_ready, q.size() < 2);
      check("rnd wb_valid", wb_valid, q.size() > 0);
      if (q.size() > 0) begin
        check("rnd wb_out", {wb_rd, wb_data, wb_wen},
              {q[0].rd, q[0].result, q[0].wen && !word_bad(q[0])});
      end else begin
        check("rnd idle out", {wb_rd, wb_data, wb_wen}, 0);
      end
      check("rnd flags", {flag_zero, flag_neg, flag_carry, err_invalid}, {mz, mn, mc, merr});

      for (int t = 0; t < W; t++) w.result[2*t +: 2] = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 11) == 0) w.result[2*$urandom_range(0, W-1) +: 2] = 2'b11;
      w.carry = ($urandom_range(0, 23) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      w.zero = 1'($urandom); w.neg = 1'($urandom); w.rd = RW'($urandom);
      w.wen = 1'($urandom); w.fupd = 1'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      r   = ($urandom_range(0, 149) == 0);
      drive(w, v);
      wb_ready = rdy;
      rst = r;

      if (r) begin
        q.delete();
        mz = 0; mn = 0; mc = 2'b00; merr = 0;
      end else begin
        acc = v && (q.size() < 2);
        if (q.size() > 0 && rdy) begin
          w0 = q.pop_front();
          if (word_bad(w0)) merr = 1'b1;
          else if (w0.fupd) begin
            mz = w0.zero; mn = w0.neg; mc = w0.carry;
          end
        end
        if (acc) q.push_back(w);
      end
      tick();
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ternary_wb_stage.md
TERNARY_WB_STAGE -- requirements
Module: ternary_wb_stage

Interface
REQ-001 Parameter WIDTH, default 8, trits per data word, SHALL match the ALU datapath width.
REQ-002 Parameter RD_W, default 3, destination-register index width.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream ALU word valid.
REQ-006 in_ready  output  1  stage can accept a word.
REQ-007 in_result  input  trit_t[WIDTH]  ALU result.
REQ-008 in_carry  input  trit_t  ALU carry trit.
REQ-009 in_zero, in_neg  input  1 each  ALU zero and negative flags.
REQ-010 in_rd  input  RD_W  destination register index.
REQ-011 in_wen  input  1  word targets the register file.
REQ-012 in_fupd  input  1  word updates architectural flags (ADD/SUB/CMP).
REQ-013 wb_valid  output  1  writeback word valid.
REQ-014 wb_ready  input  1  register file accepts the word.
REQ-015 wb_data  output  trit_t[WIDTH]; wb_rd  output  RD_W; wb_wen  output  1.
REQ-016 flag_zero, flag_neg  output  1 each; flag_carry  output  trit_t  architectural flags.
REQ-017 err_invalid  output  1  sticky flag for an invalid trit seen.
REQ-018 fwd_valid  output  1; fwd_rd  output  RD_W; fwd_data  output  trit_t[WIDTH]  bypass to the operand stage.

Function
REQ-019 Input handshake SHALL complete when in_valid and in_ready are both high; output handshake SHALL complete when wb_valid and wb_ready are both high.
REQ-020 Storage SHALL be a 2-entry skid buffer (output register plus skid register) holding result, carry, zero, neg, rd, wen and fupd.
REQ-021 in_ready SHALL be registered and equal to "skid register empty".
REQ-022 Latency SHALL be 1 cycle: a word accepted at edge N SHALL appear on wb_* after edge N, provided the output register is empty or drains at edge N.
REQ-023 Output stalled (wb_ready low) with the output register full: an accepted word SHALL go to the skid register, and in_ready SHALL fall on the next cycle.
REQ-024 Output drain with the skid register full: the skid word SHALL move to the output register, and in_ready SHALL rise on the next cycle.
REQ-025 Ordering SHALL be strict FIFO; words SHALL NOT be dropped or duplicated.
REQ-026 Flags SHALL update only at the output handshake of a word with fupd=1: flag_zero<=zero, flag_neg<=neg, flag_carry<=carry; otherwise they SHALL hold.
REQ-027 A word containing any T_INVALID trit (result or carry) SHALL be emitted with wb_wen forced to 0 and SHALL NOT update flags; err_invalid SHALL set at its output handshake and clear only on rst.
REQ-028 Simultaneous accept and drain with the output register full and the skid register empty: the new word SHALL go straight to the output register.

Reset
REQ-029 On rst, both entries SHALL empty: wb_valid=0, in_ready=1, flag_zero=0, flag_neg=0, flag_carry=T_ZERO, err_invalid=0, fwd_valid=0.
REQ-030 rst asserted mid-stall SHALL discard buffered words with no handshake completion in that cycle.
REQ-031 wb_data, wb_rd and wb_wen SHALL be all-T_ZERO, 0 and 0 while wb_valid=0.

Configuration
REQ-032 Macro TERNARY_WB_FWD_EN defined: fwd_valid SHALL equal wb_valid and wb_wen, with fwd_rd=wb_rd and fwd_data=wb_data.
REQ-033 Macro TERNARY_WB_FWD_EN undefined: the fwd_* ports SHALL remain, tied to 0, 0 and all-T_ZERO.

Structure
REQ-034 trit_t, T_ZERO, T_POS_ONE, T_NEG_ONE and T_INVALID SHALL come from ternary_pkg.
REQ-035 A wb_entry_t packed struct (result, carry, zero, neg, rd, wen, fupd) SHALL be added to ternary_pkg.
REQ-036 One sub-module, ternary_skid_buf (parameterised on the payload type width), SHALL implement the handshake; validity checking and flag logic SHALL remain in the top module.

Verification
REQ-037 Single word result=+1 (T_POS_ONE at trit 0, others zero), rd=3, wen=1, fupd=1, wb_ready=1 -> wb_valid one cycle later with rd=3, then flag_zero=0, flag_neg=0.
REQ-038 wb_ready=0 for 3 cycles with 3 words offered -> 2 accepted, in_ready=0 after the second; release -> output order word1, word2, then word3.
REQ-039 CMP word with zero=1, carry=T_NEG_ONE, fupd=1, followed by a word with fupd=0 -> flags hold zero=1, carry=T_NEG_ONE.
REQ-040 in_result trit 5 = T_INVALID, wen=1 -> wb_wen=0, flags unchanged, err_invalid=1 until rst.
REQ-041 rst asserted while both entries are full -> next cycle wb_valid=0, in_ready=1, flag_carry=T_ZERO.
REQ-042 With TERNARY_WB_FWD_EN defined, word rd=2, wen=1 held stalled -> fwd_valid=1, fwd_rd=2 throughout the stall; with the macro undefined -> fwd_valid=0.
